// File: rtl/mem_access_stage.sv
// Memory stage of the RISC-V pipeline: consumes one EX/MEM entry per handshake,
// performs the load/store over a req/ack bus with a bounded wait, and registers the MEM/WB result.
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        jal_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [31:0] pc4_in,
  input  logic [4:0]  rd_addr_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd_addr,
  output logic [31:0] wb_data,
  output logic        mem_misaligned,
  output logic        mem_timeout
);

  // Handshake: an entry transfers on a rising edge with in_valid && in_ready;
  // upstream must hold the entry stable while in_ready is low.

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;

  logic        lat_reg_write, lat_jal, lat_load;
  logic [4:0]  lat_rd;
  logic [31:0] lat_alu, lat_pc4;

  logic        accept, mem_op, misaligned, start_access, ack_done, timed_out;

  logic        wb_valid_nxt, wb_reg_write_nxt, mis_nxt, tmo_nxt;
  logic [4:0]  wb_rd_nxt;
  logic [31:0] wb_data_nxt;

  assign in_ready     = (state == IDLE);
  assign accept       = in_valid && in_ready;
  assign mem_op       = mem_read_in || mem_write_in;
  assign misaligned   = (alu_result_in[1:0] != 2'b00);
  assign start_access = accept && mem_op && !misaligned;
  assign ack_done     = (state == WAIT) && dmem_ack;
  // An ack in the last allowed cycle takes priority over abandoning the access.
  assign timed_out    = (state == WAIT) && !dmem_ack && (wait_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_access) state_nxt = WAIT;
      WAIT: if (ack_done || timed_out) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_valid_nxt     = 1'b0;
    wb_reg_write_nxt = 1'b0;
    wb_rd_nxt        = wb_rd_addr;
    wb_data_nxt      = wb_data;
    mis_nxt          = 1'b0;
    tmo_nxt          = mem_timeout;
    if (accept && !start_access) begin
      wb_valid_nxt     = 1'b1;
      wb_reg_write_nxt = reg_write_in && !(mem_op && misaligned);
      wb_rd_nxt        = rd_addr_in;
      wb_data_nxt      = jal_in ? pc4_in : alu_result_in;
      mis_nxt          = mem_op && misaligned;
    end else if (ack_done) begin
      wb_valid_nxt     = 1'b1;
      wb_reg_write_nxt = lat_reg_write;
      wb_rd_nxt        = lat_rd;
      wb_data_nxt      = lat_jal ? lat_pc4 : (lat_load ? dmem_rdata : lat_alu);
    end else if (timed_out) begin
      wb_valid_nxt     = 1'b1;
      wb_rd_nxt        = lat_rd;
      wb_data_nxt      = lat_jal ? lat_pc4 : lat_alu;
      tmo_nxt          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_rd_addr     <= '0;
      wb_data        <= '0;
      mem_misaligned <= 1'b0;
      mem_timeout    <= 1'b0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      wait_cnt       <= '0;
      lat_reg_write  <= 1'b0;
      lat_jal        <= 1'b0;
      lat_load       <= 1'b0;
      lat_rd         <= '0;
      lat_alu        <= '0;
      lat_pc4        <= '0;
    end else begin
      wb_valid       <= wb_valid_nxt;
      wb_reg_write   <= wb_reg_write_nxt;
      wb_rd_addr     <= wb_rd_nxt;
      wb_data        <= wb_data_nxt;
      mem_misaligned <= mis_nxt;
      mem_timeout    <= tmo_nxt;
      if (start_access) begin
        // Read+write together is a store, so it never returns load data.
        dmem_req      <= 1'b1;
        dmem_we       <= mem_write_in;
        dmem_addr     <= {alu_result_in[31:2], 2'b00};
        dmem_wdata    <= store_data_in;
        wait_cnt      <= '0;
        lat_reg_write <= reg_write_in;
        lat_jal       <= jal_in;
        lat_load      <= mem_read_in && !mem_write_in && mem_to_reg_in;
        lat_rd        <= rd_addr_in;
        lat_alu       <= alu_result_in;
        lat_pc4       <= pc4_in;
      end else if (ack_done || timed_out) begin
        dmem_req      <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt      <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases with literal expectations, then random
// entries and memory delays checked every cycle against a transaction-level model.
module tb_mem_access_stage;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0, mem_to_reg_in = 1'b0;
  logic        reg_write_in = 1'b0, jal_in = 1'b0;
  logic [31:0] alu_result_in = '0, store_data_in = '0, pc4_in = '0;
  logic [4:0]  rd_addr_in = '0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, wb_reg_write, mem_misaligned, mem_timeout;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_data;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .jal_in(jal_in), .alu_result_in(alu_result_in),
    .store_data_in(store_data_in), .pc4_in(pc4_in), .rd_addr_in(rd_addr_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
    .mem_misaligned(mem_misaligned), .mem_timeout(mem_timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model state ----------------
  typedef struct {
    int          due;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        dk;
    logic        mis;
    logic        tmo;
  } exp_t;

  exp_t        exp_q[$];
  int          busy_from = 0, busy_to = 0, cur_delay = 0;
  logic [31:0] cur_rdata = '0, exp_addr = '0, exp_wdata = '0;
  logic        exp_we = 1'b0;
  logic        model_tmo = 1'b0;
  logic [31:0] last_data = '0;
  logic [4:0]  last_rd = '0;
  logic        data_known = 1'b1;
  bit          checking = 1'b0;

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    busy_from = 0;
    busy_to = 0;
    model_tmo = 1'b0;
    last_data = '0;
    last_rd = '0;
    data_known = 1'b1;
  endtask

  // ---------------- memory responder ----------------
  always @(negedge clk) begin
    if (cyc >= busy_from && cyc < busy_to) begin
      dmem_ack   = ((cyc - busy_from) == cur_delay);
      dmem_rdata = dmem_ack ? cur_rdata : $urandom;
    end else begin
      // stray acks while idle must be ignored
      dmem_ack   = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin : cmp
    logic exp_busy, ev;
    exp_t e;
    if (checking && rst_n) begin
      exp_busy = (cyc >= busy_from && cyc < busy_to);
      check("in_ready", {31'b0, in_ready}, {31'b0, !exp_busy});
      check("dmem_req", {31'b0, dmem_req}, {31'b0, exp_busy});
      if (exp_busy) begin
        check("dmem_addr", dmem_addr, exp_addr);
        check("dmem_we", {31'b0, dmem_we}, {31'b0, exp_we});
        check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("wb_missing", 32'(exp_q[0].due), 32'(cyc));
        void'(exp_q.pop_front());
      end
      ev = (exp_q.size() > 0 && exp_q[0].due == cyc);
      check("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
      if (ev) begin
        e = exp_q.pop_front();
        check("wb_reg_write", {31'b0, wb_reg_write}, {31'b0, e.rw});
        check("wb_rd_addr", {27'b0, wb_rd_addr}, {27'b0, e.rd});
        check("mem_misaligned", {31'b0, mem_misaligned}, {31'b0, e.mis});
        if (e.dk) check("wb_data", wb_data, e.data);
        if (e.tmo) model_tmo = 1'b1;
        last_rd = e.rd;
        last_data = e.data;
        data_known = e.dk;
      end else begin
        check("mis_idle", {31'b0, mem_misaligned}, 32'd0);
        check("wb_rd_hold", {27'b0, wb_rd_addr}, {27'b0, last_rd});
        if (data_known) check("wb_data_hold", wb_data, last_data);
      end
      check("mem_timeout", {31'b0, mem_timeout}, {31'b0, model_tmo});
    end
  end

  // ---------------- driver ----------------
  // Call just after a rising edge; returns once the entry is accepted (acc = accept cycle).
  task automatic send(input logic rd_, input logic wr_, input logic m2r, input logic rw,
                      input logic jal, input logic [31:0] alu, input logic [31:0] sd,
                      input logic [31:0] pc4, input logic [4:0] rd, input int delay,
                      input logic [31:0] rdata, output int acc);
    logic ok;
    int   budget;
    logic mem, mis, load;
    exp_t e;
    mem_read_in = rd_; mem_write_in = wr_; mem_to_reg_in = m2r; reg_write_in = rw;
    jal_in = jal; alu_result_in = alu; store_data_in = sd; pc4_in = pc4; rd_addr_in = rd;
    in_valid = 1'b1;
    ok = 1'b0;
    budget = 0;
    acc = -1;
    while (!ok && budget < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    alu_result_in = $urandom;
    rd_addr_in = 5'($urandom);
    if (!ok) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    acc = cyc;
    mem  = rd_ || wr_;
    mis  = mem && (alu[1:0] != 2'b00);
    load = rd_ && !wr_ && m2r;
    e.rd = rd;
    e.mis = mis;
    e.tmo = 1'b0;
    if (!mem || mis) begin
      e.due = acc;
      e.rw = rw && !mis;
      e.data = jal ? pc4 : alu;
      e.dk = !mis || jal || !load;
    end else begin
      exp_addr = {alu[31:2], 2'b00};
      exp_we = wr_;
      exp_wdata = sd;
      cur_delay = delay;
      cur_rdata = rdata;
      busy_from = acc;
      if (delay < MW) begin
        busy_to = acc + delay + 1;
        e.due = acc + delay + 1;
        e.rw = rw;
        e.data = jal ? pc4 : (load ? rdata : alu);
        e.dk = 1'b1;
      end else begin
        busy_to = acc + MW;
        e.due = acc + MW;
        e.rw = 1'b0;
        e.tmo = 1'b1;
        e.data = jal ? pc4 : alu;
        e.dk = jal || !load;
      end
    end
    exp_q.push_back(e);
  endtask

  // Waits for the next wb_valid (bounded) and records what the memory bus showed meanwhile.
  task automatic wait_wb(output int lo, output int rq, output logic [31:0] a,
                         output logic w, output logic [31:0] wd);
    logic found;
    lo = 0; rq = 0; a = '0; w = 1'b0; wd = '0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (wb_valid) found = 1'b1;
      else begin
        if (!in_ready) lo++;
        if (dmem_req) begin
          rq++; a = dmem_addr; w = dmem_we; wd = dmem_wdata;
        end
      end
    end
    if (!found) check("wb_wait_timeout", 32'd0, 32'd1);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int acc, acc2, lo, rq, gap, d;
    logic [31:0] a, wd, alu;
    logic w;

    #1 rst_n = 1'b0;
    #3;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_timeout", {31'b0, mem_timeout}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;
    next_edge();

    // ALU op
    send(0, 0, 0, 1, 0, 32'h10, 32'h0, 32'h4, 5'd5, 0, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("alu_wb_data", wb_data, 32'h10);
    check("alu_wb_rd", {27'b0, wb_rd_addr}, 32'd5);
    check("alu_wb_rw", {31'b0, wb_reg_write}, 32'd1);
    next_edge();

    // load, acked in the second request cycle
    send(1, 0, 1, 1, 0, 32'h100, 32'h0, 32'h8, 5'd7, 1, 32'hDEADBEEF, acc);
    wait_wb(lo, rq, a, w, wd);
    check("ld_addr", a, 32'h100);
    check("ld_we", {31'b0, w}, 32'd0);
    check("ld_ready_low", 32'(lo), 32'd2);
    check("ld_wb_data", wb_data, 32'hDEADBEEF);
    next_edge();

    // store, immediate ack
    send(0, 1, 0, 0, 0, 32'h204, 32'h12345678, 32'hC, 5'd3, 0, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("st_we", {31'b0, w}, 32'd1);
    check("st_wdata", wd, 32'h12345678);
    check("st_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    next_edge();

    // store followed directly by an ALU op: accepted on the edge after the ack
    send(0, 1, 0, 0, 0, 32'h208, 32'hCAFEF00D, 32'h10, 5'd0, 0, 32'h0, acc);
    send(0, 0, 0, 1, 0, 32'h55, 32'h0, 32'h14, 5'd9, 0, 32'h0, acc2);
    check("st_next_accept", 32'(acc2 - acc), 32'd2);
    next_edge();
    next_edge();

    // jal
    send(0, 0, 0, 1, 1, 32'h99, 32'h0, 32'h48, 5'd1, 0, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("jal_wb_data", wb_data, 32'h48);
    next_edge();

    // misaligned load
    send(1, 0, 1, 1, 0, 32'h102, 32'h0, 32'h50, 5'd4, 0, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("mis_req_cycles", 32'(rq), 32'd0);
    check("mis_pulse", {31'b0, mem_misaligned}, 32'd1);
    check("mis_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    next_edge();

    // load never acked
    send(1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h54, 5'd6, 100, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("tmo_req_cycles", 32'(rq), 32'd4);
    check("tmo_flag", {31'b0, mem_timeout}, 32'd1);
    check("tmo_wb_rw", {31'b0, wb_reg_write}, 32'd0);
    next_edge();

    // random entries, delays straddling the timeout boundary
    for (int n = 0; n < 300; n++) begin
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      d = $urandom_range(0, MW + 1);
      send(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0), alu, $urandom, $urandom, 5'($urandom),
           d, $urandom, acc);
      gap = $urandom_range(0, 2);
      repeat (gap) next_edge();
    end
    repeat (MW + 6) next_edge();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of an access
    send(1, 0, 1, 1, 0, 32'h400, 32'h0, 32'h58, 5'd2, 100, 32'h0, acc);
    next_edge();
    #2 rst_n = 1'b0;
    checking = 1'b0;
    #1;
    check("rst_mid_req", {31'b0, dmem_req}, 32'd0);
    check("rst_mid_tmo", {31'b0, mem_timeout}, 32'd0);
    check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    clear_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checking = 1'b1;
    next_edge();
    send(0, 0, 0, 1, 0, 32'h77, 32'h0, 32'h5C, 5'd8, 0, 32'h0, acc);
    wait_wb(lo, rq, a, w, wd);
    check("post_rst_wb_data", wb_data, 32'h77);
    repeat (3) next_edge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
